// File: rtl/ahb_bridge_pkg.sv
// Shared AHB bridge types and constants: transfer codes, one-hot burst
// behaviour encoding (common with the master-side encoder) and tracker states.
package ahb_bridge_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic [7:0] BHV_SINGLE = 8'b0000_0001;
   localparam logic [7:0] BHV_INCR   = 8'b0000_0010;
   localparam logic [7:0] BHV_WRAP4  = 8'b0000_0100;
   localparam logic [7:0] BHV_INCR4  = 8'b0000_1000;
   localparam logic [7:0] BHV_WRAP8  = 8'b0001_0000;
   localparam logic [7:0] BHV_INCR8  = 8'b0010_0000;
   localparam logic [7:0] BHV_WRAP16 = 8'b0100_0000;
   localparam logic [7:0] BHV_INCR16 = 8'b1000_0000;

   localparam logic [7:0] BHV_WRAP_MASK = BHV_WRAP4 | BHV_WRAP8 | BHV_WRAP16;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } tracker_state_t;

   // Length 0 marks the undefined-length INCR burst; anything not one-hot falls back to SINGLE.
   function automatic logic [4:0] bhv_to_len(input logic [7:0] bhv);
      logic [4:0] len;
      case (bhv)
         BHV_INCR:               len = 5'd0;
         BHV_WRAP4,  BHV_INCR4:  len = 5'd4;
         BHV_WRAP8,  BHV_INCR8:  len = 5'd8;
         BHV_WRAP16, BHV_INCR16: len = 5'd16;
         default:                len = 5'd1;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/ahb_next_addr_calc.sv
// Combinational next-beat address for AHB INCR and WRAP bursts; shared by the
// slave-side tracker and the master-side address generator.
module ahb_next_addr_calc #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [2:0]            size,
   input  logic [4:0]            len,
   input  logic                  wrap,
   output logic [ADDR_WIDTH-1:0] next
);

   logic [ADDR_WIDTH-1:0] incr;
   logic [ADDR_WIDTH-1:0] boundary;
   logic [ADDR_WIDTH-1:0] mask;
   logic [ADDR_WIDTH-1:0] linear;

   // A wrapping burst keeps the upper bits fixed and lets only the low bits inside the boundary roll over.
   always_comb begin
      incr     = ADDR_WIDTH'(1) << size;
      boundary = ADDR_WIDTH'(len) << size;
      mask     = boundary - ADDR_WIDTH'(1);
      linear   = addr + incr;
      next     = wrap ? ((addr & ~mask) | (linear & mask)) : linear;
   end

endmodule

// File: rtl/ahb_burst_addr_tracker.sv
// Slave-side AHB burst tracker: follows each burst beat by beat, predicts the
// next address and flags last beat, address mismatch, early end and bad codes.
module ahb_burst_addr_tracker
   import ahb_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic                  HREADY,
   input  logic [1:0]            HTRANS,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [2:0]            HSIZE,
   input  logic [7:0]            SIGNAL_BEHAVIOR,
   output logic [ADDR_WIDTH-1:0] NEXT_ADDR,
   output logic [4:0]            BEAT_CNT,
   output logic                  BURST_ACTIVE,
   output logic                  BURST_LAST,
   output logic                  ADDR_ERR,
   output logic                  EARLY_TERM,
   output logic                  BEHAVE_ERR
);

   localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

   tracker_state_t        state_q, state_d;
   logic [4:0]            len_q, len_d;
   logic                  wrap_q, wrap_d;
   logic [2:0]            size_q, size_d;
   logic [4:0]            beat_cnt_q, beat_cnt_d;
   logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
   logic                  burst_active_q, burst_active_d;
   logic                  burst_last_q, burst_last_d;
   logic                  addr_err_q, addr_err_d;
   logic                  early_term_q, early_term_d;
   logic                  behave_err_q, behave_err_d;

   htrans_t               trans;
   logic                  bhv_illegal;
   logic [4:0]            new_len;
   logic                  new_wrap;
   logic                  start;
   logic [4:0]            calc_len;
   logic                  calc_wrap;
   logic [2:0]            calc_size;
   logic [ADDR_WIDTH-1:0] calc_next;

   assign trans       = htrans_t'(HTRANS);
   assign bhv_illegal = ($countones(SIGNAL_BEHAVIOR) != 1) || (HSIZE > MAX_SIZE);
   assign new_len     = bhv_illegal ? 5'd1 : bhv_to_len(SIGNAL_BEHAVIOR);
   assign new_wrap    = !bhv_illegal && (|(SIGNAL_BEHAVIOR & BHV_WRAP_MASK));

   // A starting beat predicts with the incoming burst shape, a continuing beat with the captured one.
   assign calc_len  = start ? new_len  : len_q;
   assign calc_wrap = start ? new_wrap : wrap_q;
   assign calc_size = start ? HSIZE    : size_q;

   ahb_next_addr_calc #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_next_addr_calc (
      .addr (HADDR),
      .size (calc_size),
      .len  (calc_len),
      .wrap (calc_wrap),
      .next (calc_next)
   );

   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      wrap_d         = wrap_q;
      size_d         = size_q;
      beat_cnt_d     = beat_cnt_q;
      next_addr_d    = next_addr_q;
      burst_active_d = burst_active_q;
      burst_last_d   = 1'b0;
      addr_err_d     = 1'b0;
      early_term_d   = 1'b0;
      behave_err_d   = 1'b0;
      start          = 1'b0;

      if (HSEL && HREADY) begin
         case (state_q)
            ST_IDLE: begin
               if (trans == HTRANS_NONSEQ) begin
                  start = 1'b1;
               end else if (trans == HTRANS_SEQ) begin
                  addr_err_d = 1'b1;
               end
            end
            ST_BURST: begin
               case (trans)
                  HTRANS_NONSEQ: begin
                     early_term_d = (len_q != 5'd0);
                     start        = 1'b1;
                  end
                  HTRANS_SEQ: begin
                     addr_err_d  = (HADDR != next_addr_q);
                     next_addr_d = calc_next;
                     if (beat_cnt_q != 5'd31) begin
                        beat_cnt_d = beat_cnt_q + 5'd1;
                     end
                     if ((len_q != 5'd0) && ((beat_cnt_q + 5'd1) == len_q)) begin
                        burst_last_d   = 1'b1;
                        state_d        = ST_IDLE;
                        burst_active_d = 1'b0;
                     end
                  end
                  HTRANS_IDLE: begin
                     early_term_d   = (len_q != 5'd0);
                     state_d        = ST_IDLE;
                     burst_active_d = 1'b0;
                  end
                  default: begin
                  end
               endcase
            end
            default: begin
            end
         endcase
      end

      if (start) begin
         behave_err_d = bhv_illegal;
         len_d        = new_len;
         wrap_d       = new_wrap;
         size_d       = HSIZE;
         beat_cnt_d   = 5'd1;
         next_addr_d  = calc_next;
         if (new_len == 5'd1) begin
            burst_last_d   = 1'b1;
            state_d        = ST_IDLE;
            burst_active_d = 1'b0;
         end else begin
            state_d        = ST_BURST;
            burst_active_d = 1'b1;
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q        <= ST_IDLE;
         len_q          <= '0;
         wrap_q         <= 1'b0;
         size_q         <= '0;
         beat_cnt_q     <= '0;
         next_addr_q    <= '0;
         burst_active_q <= 1'b0;
         burst_last_q   <= 1'b0;
         addr_err_q     <= 1'b0;
         early_term_q   <= 1'b0;
         behave_err_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         len_q          <= len_d;
         wrap_q         <= wrap_d;
         size_q         <= size_d;
         beat_cnt_q     <= beat_cnt_d;
         next_addr_q    <= next_addr_d;
         burst_active_q <= burst_active_d;
         burst_last_q   <= burst_last_d;
         addr_err_q     <= addr_err_d;
         early_term_q   <= early_term_d;
         behave_err_q   <= behave_err_d;
      end
   end

   assign NEXT_ADDR    = next_addr_q;
   assign BEAT_CNT     = beat_cnt_q;
   assign BURST_ACTIVE = burst_active_q;
   assign BURST_LAST   = burst_last_q;
   assign ADDR_ERR     = addr_err_q;
   assign EARLY_TERM   = early_term_q;
   assign BEHAVE_ERR   = behave_err_q;

endmodule
